// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C target engine with START/STOP detection, 7-bit address match,
// rx strobe for master writes and tx handshake for master reads; sda is open-drain only.
module i2c_slave_fsm #(
    parameter int               DATA_SIZE  = 8,
    parameter logic [6:0]       SLAVE_ADDR = 7'h3C
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 reset_ni,
    input  logic                 enable_i,
    input  logic                 scl_i,
    input  logic                 sda_i,
    input  logic                 rx_full_i,
    input  logic [DATA_SIZE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 sda_low_en_o,
    output logic [DATA_SIZE-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 tx_req_o,
    output logic                 tx_underrun_o,
    output logic                 rw_o,
    output logic                 busy_o,
    output logic                 stop_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_WAIT_STOP
    } state_t;

    localparam logic [3:0] LAST = 4'(DATA_SIZE - 1);
    localparam logic [3:0] FULL = 4'(DATA_SIZE);

    logic r_scl_s1, r_scl_s2, r_scl_h, r_sda_s1, r_sda_s2, r_sda_h;
    state_t r_state, w_state_n;
    logic [3:0] r_bit_cnt, w_cnt_n;
    logic [DATA_SIZE-1:0] r_shift, w_shift_n, r_tx_shift, w_tx_n, r_rx_data, w_rx_data_n;
    logic r_sda_low, w_sda_n, r_rw, w_rw_n, r_busy, w_busy_n, r_ack, w_ack_n;
    logic r_rx_valid, w_rx_valid, r_tx_req, w_tx_req, r_underrun, w_underrun, r_stop, w_stop;
    logic w_load;

    wire w_scl_rise = r_scl_s2 & ~r_scl_h;
    wire w_scl_fall = ~r_scl_s2 & r_scl_h;
    wire w_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
    wire w_stop_det = r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
    wire [DATA_SIZE-1:0] w_byte = {r_shift[DATA_SIZE-2:0], r_sda_s2};

    // Lines idle high, so the synchronizers reset to 1 to avoid a false edge after reset.
    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_h} <= 3'b111;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_h} <= {scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_h} <= {sda_i, r_sda_s1, r_sda_s2};
        end
    end

    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx_shift <= '0;
            r_rx_data  <= '0;
            r_sda_low  <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_underrun <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_bit_cnt  <= w_cnt_n;
            r_shift    <= w_shift_n;
            r_tx_shift <= w_tx_n;
            r_rx_data  <= w_rx_data_n;
            r_sda_low  <= w_sda_n;
            r_rw       <= w_rw_n;
            r_busy     <= w_busy_n;
            r_ack      <= w_ack_n;
            r_rx_valid <= w_rx_valid;
            r_tx_req   <= w_tx_req;
            r_underrun <= w_underrun;
            r_stop     <= w_stop;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_bit_cnt;
        w_shift_n   = r_shift;
        w_tx_n      = r_tx_shift;
        w_rx_data_n = r_rx_data;
        w_sda_n     = r_sda_low;
        w_rw_n      = r_rw;
        w_busy_n    = r_busy;
        w_ack_n     = r_ack;
        w_rx_valid  = 1'b0;
        w_tx_req    = 1'b0;
        w_underrun  = 1'b0;
        w_stop      = 1'b0;
        w_load      = 1'b0;
        if (!enable_i) begin
            w_state_n = S_IDLE;
            w_sda_n   = 1'b0;
            w_busy_n  = 1'b0;
            w_cnt_n   = '0;
        end else if (w_stop_det) begin
            w_state_n = S_IDLE;
            w_sda_n   = 1'b0;
            w_busy_n  = 1'b0;
            w_cnt_n   = '0;
            w_stop    = 1'b1;
        end else if (w_start) begin
            w_state_n = S_ADDR;
            w_sda_n   = 1'b0;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise && r_bit_cnt != FULL) begin
                        w_shift_n = w_byte;
                        w_cnt_n   = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == LAST) begin
                            if (w_byte[DATA_SIZE-1:1] == SLAVE_ADDR) begin
                                w_rw_n   = w_byte[0];
                                w_busy_n = 1'b1;
                            end else begin
                                w_state_n = S_WAIT_STOP;
                            end
                        end
                    end else if (w_scl_fall && r_bit_cnt == FULL) begin
                        w_state_n = S_ADDR_ACK;
                        w_sda_n   = 1'b1;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_n   = '0;
                        w_sda_n   = 1'b0;
                        w_state_n = S_WRITE;
                        w_load    = r_rw;
                    end
                end
                S_WRITE: begin
                    if (w_scl_rise && r_bit_cnt != FULL) begin
                        w_shift_n = w_byte;
                        w_cnt_n   = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == LAST) begin
                            w_ack_n     = ~rx_full_i;
                            w_rx_valid  = ~rx_full_i;
                            w_rx_data_n = rx_full_i ? r_rx_data : w_byte;
                        end
                    end else if (w_scl_fall && r_bit_cnt == FULL) begin
                        w_state_n = S_WRITE_ACK;
                        w_sda_n   = r_ack;
                    end
                end
                S_WRITE_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_n   = '0;
                        w_sda_n   = 1'b0;
                        w_state_n = r_ack ? S_WRITE : S_WAIT_STOP;
                    end
                end
                S_READ: begin
                    if (w_scl_fall && r_bit_cnt == LAST) begin
                        w_state_n = S_READ_ACK;
                        w_sda_n   = 1'b0;
                    end else if (w_scl_fall) begin
                        w_cnt_n = r_bit_cnt + 4'd1;
                        w_tx_n  = {r_tx_shift[DATA_SIZE-2:0], 1'b0};
                        w_sda_n = ~w_tx_n[DATA_SIZE-1];
                    end
                end
                S_READ_ACK: begin
                    // r_ack here holds the master's ACK (1) / NACK (0) from the 9th bit.
                    if (w_scl_rise) begin
                        w_ack_n = ~r_sda_s2;
                    end else if (w_scl_fall) begin
                        w_cnt_n   = '0;
                        w_state_n = S_WAIT_STOP;
                        w_load    = r_ack;
                    end
                end
                S_IDLE, S_WAIT_STOP: ;
                default: w_state_n = S_IDLE;
            endcase
            if (w_load) begin
                w_state_n  = S_READ;
                w_tx_n     = tx_valid_i ? tx_data_i : '1;
                w_sda_n    = ~w_tx_n[DATA_SIZE-1];
                w_tx_req   = tx_valid_i;
                w_underrun = ~tx_valid_i;
            end
        end
    end

    assign sda_low_en_o  = r_sda_low;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_req_o      = r_tx_req;
    assign tx_underrun_o = r_underrun;
    assign rw_o          = r_rw;
    assign busy_o        = r_busy;
    assign stop_o        = r_stop;
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb_i2c_slave_fsm: directed I2C master stimulus against i2c_slave_fsm with inline checks.
`timescale 1ns/1ps
module tb_i2c_slave_fsm;
    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, scl = 1'b1, msda = 1'b1;
    logic       rx_full = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_low, rx_valid, tx_req, und, rw, busy, stop;
    logic [7:0] rx_data;
    wire        sda_line = msda & ~sda_low;
    int checks = 0, failures = 0;
    int n_rx = 0, n_txr = 0, n_und = 0, n_stop = 0, n_multi = 0, n_drv = 0, n_busy = 0;

    i2c_slave_fsm #(.DATA_SIZE(8), .SLAVE_ADDR(7'h3C)) dut (
        .i2c_core_clk_i(clk), .reset_ni(rst_n), .enable_i(en), .scl_i(scl), .sda_i(sda_line),
        .rx_full_i(rx_full), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .sda_low_en_o(sda_low), .rx_data_o(rx_data), .rx_valid_o(rx_valid), .tx_req_o(tx_req),
        .tx_underrun_o(und), .rw_o(rw), .busy_o(busy), .stop_o(stop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) n_rx++;
        if (tx_req) n_txr++;
        if (und) n_und++;
        if (stop) n_stop++;
        if (sda_low) n_drv++;
        if (busy) n_busy++;
        if (int'(rx_valid) + int'(tx_req) + int'(und) + int'(stop) > 1) n_multi++;
    end

    task automatic q();
        repeat (8) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic o);
        msda = b; q();
        scl = 1'b1; q();
        o = sda_line; q();
        scl = 1'b0; q();
    endtask

    task automatic i2c_start();
        msda = 1'b1; q();
        scl = 1'b1; q();
        msda = 1'b0; q();
        scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        msda = 1'b0; q();
        scl = 1'b1; q();
        msda = 1'b1; q(); q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic o;
        for (int i = 7; i >= 0; i--) bit_io(b[i], o);
        bit_io(1'b1, o);
        ack = ~o;
    endtask

    task automatic read_byte(input logic mack, input logic [7:0] nxt, output logic [7:0] d);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, o);
            d[i] = o;
        end
        tx_data = nxt;
        bit_io(~mack, o);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++; if ({sda_low, rx_valid, tx_req, und, rw, busy, stop} !== 7'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=0000000", {sda_low, rx_valid, tx_req, und, rw, busy, stop}); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        rst_n = 1'b1;
        q();
    endtask

    task automatic test_write();
        logic a; int b_rx = n_rx, b_stop = n_stop;
        i2c_start();
        send_byte(8'h78, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_addr_ack got=%b exp=1", a); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
        checks++; if (rw !== 1'b0) begin failures++; $display("FAIL wr_rw got=%b exp=0", rw); end
        send_byte(8'hA5, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL wr_data_ack got=%b exp=1", a); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL wr_rx_data got=%h exp=a5", rx_data); end
        i2c_stop();
        checks++; if (n_rx - b_rx !== 1) begin failures++; $display("FAIL wr_rx_pulses got=%0d exp=1", n_rx - b_rx); end
        checks++; if (n_stop - b_stop !== 1) begin failures++; $display("FAIL wr_stop_pulses got=%0d exp=1", n_stop - b_stop); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_addr_mismatch();
        logic a; int b_rx = n_rx, b_drv = n_drv, b_busy = n_busy, b_stop = n_stop;
        i2c_start();
        send_byte(8'h7A, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL mm_addr_ack got=%b exp=0", a); end
        send_byte(8'h55, a);
        i2c_stop();
        checks++; if (n_drv - b_drv !== 0) begin failures++; $display("FAIL mm_sda_driven got=%0d exp=0", n_drv - b_drv); end
        checks++; if (n_rx - b_rx !== 0) begin failures++; $display("FAIL mm_rx_pulses got=%0d exp=0", n_rx - b_rx); end
        checks++; if (n_busy - b_busy !== 0) begin failures++; $display("FAIL mm_busy_cycles got=%0d exp=0", n_busy - b_busy); end
        checks++; if (n_stop - b_stop !== 1) begin failures++; $display("FAIL mm_stop_pulses got=%0d exp=1", n_stop - b_stop); end
    endtask

    task automatic test_read();
        logic a; logic [7:0] d; int b_txr = n_txr, b_und = n_und;
        tx_data = 8'h5A; tx_valid = 1'b1;
        i2c_start();
        send_byte(8'h79, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL rd_addr_ack got=%b exp=1", a); end
        checks++; if (rw !== 1'b1) begin failures++; $display("FAIL rd_rw got=%b exp=1", rw); end
        read_byte(1'b1, 8'hC3, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rd_byte0 got=%h exp=5a", d); end
        read_byte(1'b0, 8'h00, d);
        checks++; if (d !== 8'hC3) begin failures++; $display("FAIL rd_byte1 got=%h exp=c3", d); end
        q();
        checks++; if (sda_low !== 1'b0) begin failures++; $display("FAIL rd_released got=%b exp=0", sda_low); end
        i2c_stop();
        checks++; if (n_txr - b_txr !== 2) begin failures++; $display("FAIL rd_tx_req_pulses got=%0d exp=2", n_txr - b_txr); end
        checks++; if (n_und - b_und !== 0) begin failures++; $display("FAIL rd_underruns got=%0d exp=0", n_und - b_und); end
    endtask

    task automatic test_underrun();
        logic a; logic [7:0] d; int b_txr = n_txr, b_und = n_und;
        tx_valid = 1'b0; tx_data = 8'h12;
        i2c_start();
        send_byte(8'h79, a);
        read_byte(1'b0, 8'h12, d);
        i2c_stop();
        checks++; if (d !== 8'hFF) begin failures++; $display("FAIL ur_byte got=%h exp=ff", d); end
        checks++; if (n_und - b_und !== 1) begin failures++; $display("FAIL ur_pulses got=%0d exp=1", n_und - b_und); end
        checks++; if (n_txr - b_txr !== 0) begin failures++; $display("FAIL ur_tx_req got=%0d exp=0", n_txr - b_txr); end
    endtask

    task automatic test_rx_full_restart();
        logic a; logic [7:0] d; int b_rx = n_rx;
        rx_full = 1'b1;
        i2c_start();
        send_byte(8'h78, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL rf_addr_ack got=%b exp=1", a); end
        send_byte(8'h11, a);
        checks++; if (a !== 1'b0) begin failures++; $display("FAIL rf_data_nack got=%b exp=0", a); end
        checks++; if (n_rx - b_rx !== 0) begin failures++; $display("FAIL rf_rx_pulses got=%0d exp=0", n_rx - b_rx); end
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL rf_rx_data_kept got=%h exp=a5", rx_data); end
        rx_full = 1'b0; tx_valid = 1'b1; tx_data = 8'h5A;
        i2c_start();
        send_byte(8'h79, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL rs_addr_ack got=%b exp=1", a); end
        checks++; if (rw !== 1'b1) begin failures++; $display("FAIL rs_rw got=%b exp=1", rw); end
        read_byte(1'b0, 8'h5A, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rs_byte got=%h exp=5a", d); end
        i2c_stop();
    endtask

    task automatic test_reset_midbyte();
        logic a, o; int b_rx;
        tx_data = 8'h00; tx_valid = 1'b1;
        i2c_start();
        send_byte(8'h79, a);
        for (int i = 0; i < 4; i++) bit_io(1'b1, o);
        checks++; if (sda_low !== 1'b1) begin failures++; $display("FAIL mr_driving got=%b exp=1", sda_low); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sda_low !== 1'b0) begin failures++; $display("FAIL mr_async_release got=%b exp=0", sda_low); end
        scl = 1'b1; msda = 1'b1;
        q();
        rst_n = 1'b1;
        q();
        b_rx = n_rx;
        i2c_start();
        send_byte(8'h78, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL mr_addr_ack got=%b exp=1", a); end
        send_byte(8'h3C, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL mr_data0_ack got=%b exp=1", a); end
        send_byte(8'h42, a);
        checks++; if (a !== 1'b1) begin failures++; $display("FAIL mr_data1_ack got=%b exp=1", a); end
        i2c_stop();
        checks++; if (rx_data !== 8'h42) begin failures++; $display("FAIL mr_rx_data got=%h exp=42", rx_data); end
        checks++; if (n_rx - b_rx !== 2) begin failures++; $display("FAIL mr_rx_pulses got=%0d exp=2", n_rx - b_rx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_underrun();
        test_rx_full_restart();
        test_reset_midbyte();
        checks++; if (n_multi !== 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", n_multi); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
